// File: rtl/sram_bist_ctrl.sv
// March C- BIST initiator for one single-port SRAM macro test port.
// Runs 10N operations, then reports pass/fail with first-failure address and count.
module sram_bist_ctrl #(
  parameter int DWidth = 64,
  parameter int AWidth = 10
) (
  input  logic              Clock,
  input  logic              Reset_N,
  input  logic              Start,
  output logic              Busy,
  output logic              Done,
  output logic              Fail,
  output logic [AWidth-1:0] FailAddr,
  output logic [15:0]       FailCount,
  output logic              TESTEN,
  output logic              TCE,
  output logic [AWidth-1:0] TA,
  output logic              TRDWEN,
  output logic [DWidth-1:0] TBW,
  output logic [DWidth-1:0] TDIN,
  input  logic [DWidth-1:0] TDOUT
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  localparam logic [AWidth-1:0] ALast = {AWidth{1'b1}};

  state_e            state_q, state_d;
  logic [2:0]        elem_q, elem_d;
  logic              phase_q, phase_d;
  logic [AWidth-1:0] addr_q, addr_d;
  logic              busy_q, busy_d, done_q, done_d, fail_q, fail_d;
  logic [AWidth-1:0] fail_addr_q, fail_addr_d;
  logic [15:0]       fail_count_q, fail_count_d;
  logic              testen_q, testen_d, tce_q, tce_d, trdwen_q, trdwen_d;
  logic [AWidth-1:0] ta_q, ta_d;
  logic [DWidth-1:0] tdin_q, tdin_d;
  logic              cmp_valid_q, cmp_valid_d;
  logic [DWidth-1:0] cmp_exp_q, cmp_exp_d;
  logic [AWidth-1:0] cmp_addr_q, cmp_addr_d;
  logic              last_op_s;
  logic [AWidth-1:0] term_addr_s;

  function automatic logic elem_up(input logic [2:0] e);
    return !((e == 3'd3) || (e == 3'd4));
  endfunction

  function automatic logic op_is_read(input logic [2:0] e, input logic ph);
    if (e == 3'd0) return 1'b0;
    if (e == 3'd5) return 1'b1;
    return !ph;
  endfunction

  // Data bit of an op: E1/E3 are (r0,w1), E2/E4 are (r1,w0), E0 and E5 use zeros
  function automatic logic op_value(input logic [2:0] e, input logic ph);
    if ((e == 3'd1) || (e == 3'd3)) return ph;
    if ((e == 3'd2) || (e == 3'd4)) return !ph;
    return 1'b0;
  endfunction

  always_comb begin
    state_d      = state_q;
    elem_d       = elem_q;
    phase_d      = phase_q;
    addr_d       = addr_q;
    busy_d       = busy_q;
    done_d       = done_q;
    fail_d       = fail_q;
    fail_addr_d  = fail_addr_q;
    fail_count_d = fail_count_q;
    testen_d     = testen_q;
    tce_d        = tce_q;
    trdwen_d     = trdwen_q;
    ta_d         = ta_q;
    tdin_d       = tdin_q;
    cmp_valid_d  = 1'b0;
    cmp_exp_d    = cmp_exp_q;
    cmp_addr_d   = cmp_addr_q;
    last_op_s    = ((elem_q == 3'd0) || (elem_q == 3'd5)) ? 1'b1 : phase_q;
    term_addr_s  = elem_up(elem_q) ? ALast : {AWidth{1'b0}};

    if (cmp_valid_q && (TDOUT != cmp_exp_q)) begin
      if (fail_count_q != 16'hFFFF) fail_count_d = fail_count_q + 16'd1;
      if (!fail_q) fail_addr_d = cmp_addr_q;
      fail_d = 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          state_d      = S_RUN;
          elem_d       = 3'd0;
          phase_d      = 1'b0;
          addr_d       = {AWidth{1'b0}};
          busy_d       = 1'b1;
          done_d       = 1'b0;
          fail_d       = 1'b0;
          fail_addr_d  = {AWidth{1'b0}};
          fail_count_d = 16'd0;
          testen_d     = 1'b1;
          tce_d        = 1'b1;
          ta_d         = {AWidth{1'b0}};
          trdwen_d     = op_is_read(3'd0, 1'b0);
          tdin_d       = {DWidth{op_value(3'd0, 1'b0)}};
        end
      end
      S_RUN: begin
        if (op_is_read(elem_q, phase_q)) begin
          cmp_valid_d = 1'b1;
          cmp_exp_d   = {DWidth{op_value(elem_q, phase_q)}};
          cmp_addr_d  = addr_q;
        end
        // Element end is found by comparing against the terminal address, never by wrap
        if (!last_op_s) begin
          phase_d = 1'b1;
        end else if (addr_q != term_addr_s) begin
          phase_d = 1'b0;
          addr_d  = elem_up(elem_q) ? addr_q + AWidth'(1) : addr_q - AWidth'(1);
        end else if (elem_q == 3'd5) begin
          state_d  = S_DRAIN;
          tce_d    = 1'b0;
          trdwen_d = 1'b1;
        end else begin
          elem_d  = elem_q + 3'd1;
          phase_d = 1'b0;
          addr_d  = elem_up(elem_q + 3'd1) ? {AWidth{1'b0}} : ALast;
        end
        if (state_d == S_RUN) begin
          ta_d     = addr_d;
          trdwen_d = op_is_read(elem_d, phase_d);
          tdin_d   = {DWidth{op_value(elem_d, phase_d)}};
        end
      end
      S_DRAIN: begin
        state_d  = S_DONE;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        testen_d = 1'b0;
        tce_d    = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset_N) begin
      state_q      <= S_IDLE;
      elem_q       <= 3'd0;
      phase_q      <= 1'b0;
      addr_q       <= {AWidth{1'b0}};
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      fail_addr_q  <= {AWidth{1'b0}};
      fail_count_q <= 16'd0;
      testen_q     <= 1'b0;
      tce_q        <= 1'b0;
      trdwen_q     <= 1'b1;
      ta_q         <= {AWidth{1'b0}};
      tdin_q       <= {DWidth{1'b0}};
      cmp_valid_q  <= 1'b0;
      cmp_exp_q    <= {DWidth{1'b0}};
      cmp_addr_q   <= {AWidth{1'b0}};
    end else begin
      state_q      <= state_d;
      elem_q       <= elem_d;
      phase_q      <= phase_d;
      addr_q       <= addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      fail_addr_q  <= fail_addr_d;
      fail_count_q <= fail_count_d;
      testen_q     <= testen_d;
      tce_q        <= tce_d;
      trdwen_q     <= trdwen_d;
      ta_q         <= ta_d;
      tdin_q       <= tdin_d;
      cmp_valid_q  <= cmp_valid_d;
      cmp_exp_q    <= cmp_exp_d;
      cmp_addr_q   <= cmp_addr_d;
    end
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Fail      = fail_q;
  assign FailAddr  = fail_addr_q;
  assign FailCount = fail_count_q;
  assign TESTEN    = testen_q;
  assign TCE       = tce_q;
  assign TA        = ta_q;
  assign TRDWEN    = trdwen_q;
  assign TBW       = {DWidth{1'b1}};
  assign TDIN      = tdin_q;

endmodule
